// File: rtl/fifo_sync_thresh_if.sv
// ---------------------------------------------------------------------------
// fifo_sync_thresh_if
//   Bundles the FIFO's producer/consumer-side signals. The port names stay
//   the same as the lab FIFO's: active-low wr_n/rd_n, din/dout and the
//   status flags.
//   Modports:
//     master : the producer/consumer side. It drives wr_n, din, rd_n and
//              err_clr, and it observes dout and all of the flags.
//     slave  : the FIFO side. It is the mirror image of the master modport.
//   Parameters WIDTH/DEPTH must match the fifo_sync_thresh instance.
// ---------------------------------------------------------------------------
interface fifo_sync_thresh_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             wr_n;
  logic [WIDTH-1:0] din;
  logic             rd_n;
  logic             err_clr;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_n, din, rd_n, err_clr,
    input  dout, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  wr_n, din, rd_n, err_clr,
    output dout, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_thresh.sv
// ---------------------------------------------------------------------------
// fifo_sync_thresh
//   This is a single-clock, first-word-fall-through FIFO with programmable
//   almost-full and almost-empty thresholds, an occupancy count, and
//   overflow/underflow reporting.
//   Ports:
//     clk      : master clock. All state changes on the rising edge.
//     reset_n  : asynchronous, active-low reset. It discards the contents.
//     bus      : fifo_sync_thresh_if.slave. It carries the wr_n/din write
//                side, the rd_n/dout read side, the status flags, count,
//                the error flags and err_clr.
//   Configuration macro FIFO_ERR_STICKY_EN:
//     defined   : overflow/underflow are sticky and are cleared by err_clr.
//     undefined : overflow/underflow are one-cycle pulses, and err_clr is
//                 ignored.
// ---------------------------------------------------------------------------
module fifo_sync_thresh #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fifo_sync_thresh_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             ovf_q,    ovf_d;
  logic             unf_q,    unf_d;
  logic             rd_ok, wr_ok, ovf_evt, unf_evt;

  // A write into a full FIFO is still accepted when a read frees a slot in
  // the same cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rd_ok    = !bus.rd_n && (count_q != '0);
    wr_ok    = !bus.wr_n && ((count_q != CW'(DEPTH)) || rd_ok);
    ovf_evt  = !bus.wr_n && !wr_ok;
    unf_evt  = !bus.rd_n && !rd_ok;

    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
    else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;

`ifdef FIFO_ERR_STICKY_EN
    // A new event wins over a same-cycle clear.
    ovf_d = ovf_evt | (ovf_q & ~bus.err_clr);
    unf_d = unf_evt | (unf_q & ~bus.err_clr);
`else
    ovf_d = ovf_evt;
    unf_d = unf_evt;
`endif
  end

`ifndef FIFO_ERR_STICKY_EN
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // NOTE: the storage array has no reset. dout is masked while the FIFO is empty, so stale words never appear.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= bus.din;
  end

  // All of the flags are decoded from the registered count only.
  assign bus.count        = count_q;
  assign bus.empty        = (count_q == '0);
  assign bus.full         = (count_q == CW'(DEPTH));
  assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
  assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
  assign bus.dout         = bus.empty ? '0 : mem[rd_ptr_q];
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule
